// File: rtl/fp24_pkg.sv
// Shared fp24 definitions: field layout, operand classes and flag bit positions.
package fp24_pkg;

  localparam int unsigned FP24_EXP_BIAS = 127;
  localparam int unsigned FP24_FRAC_W   = 15;
  localparam int unsigned FP24_EXP_W    = 8;
  localparam int unsigned FP24_W        = 1 + FP24_EXP_W + FP24_FRAC_W;

  typedef struct packed {
    logic                   sign;
    logic [FP24_EXP_W-1:0]  exp;
    logic [FP24_FRAC_W-1:0] frac;
  } fp24_t;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORMAL,
    FP_INF,
    FP_NAN
  } fp_class_e;

  // Positions within the {invalid, overflow, inexact} flag vector.
  localparam int unsigned FLAG_INEXACT  = 0;
  localparam int unsigned FLAG_OVERFLOW = 1;
  localparam int unsigned FLAG_INVALID  = 2;

endpackage

// File: rtl/fp24_classify.sv
// Combinational fp24 decode: class, unbiased exponent and mantissa with the
// hidden bit. Denormals are flushed to zero.
module fp24_classify
  import fp24_pkg::*;
(
  input  logic [FP24_W-1:0]      a_i,
  output logic                   sign_o,
  output logic [1:0]             cls_o,
  output logic [FP24_EXP_W:0]    exp_o,
  output logic [FP24_FRAC_W:0]   mant_o
);

  fp24_t     a;
  fp_class_e cls;

  assign a = fp24_t'(a_i);

  always_comb begin
    cls = FP_NORMAL;
    if (a.exp == '0) begin
      cls = FP_ZERO;
    end else if (a.exp == '1) begin
      cls = (a.frac != '0) ? FP_NAN : FP_INF;
    end
  end

  assign cls_o  = cls;
  assign sign_o = a.sign;
  // Two's-complement unbiased exponent, one bit wider than the field.
  assign exp_o  = {1'b0, a.exp} - (FP24_EXP_W + 1)'(FP24_EXP_BIAS);
  assign mant_o = {1'b1, a.frac};

endmodule

// File: rtl/fp_to_int.sv
// Two-stage valid/ready fp24 -> saturating signed integer converter, truncating
// toward zero. Define FP_TO_INT_FLAGS_EN to produce {invalid, overflow, inexact}.
module fp_to_int
  import fp24_pkg::*;
#(
  parameter int unsigned OUT_W = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [23:0]      in_a_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [OUT_W-1:0] out_int_o,
  output logic [TAG_W-1:0] out_tag_o,
  output logic [2:0]       out_flags_o
);

  localparam logic [OUT_W-1:0] INT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] INT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  // Stage 1: decoded operand.
  logic             s1_v_q, s1_v_d;
  logic             s1_sign_q, s1_sign_d;
  fp_class_e        s1_cls_q, s1_cls_d;
  logic [8:0]       s1_e_q, s1_e_d;
  logic [15:0]      s1_mant_q, s1_mant_d;
  logic [TAG_W-1:0] s1_tag_q;
  logic [1:0]       cls_raw;

  // Stage 2: converted result.
  logic             s2_v_q, s2_v_d;
  logic [OUT_W-1:0] s2_int_q, s2_int_d;
  logic [TAG_W-1:0] s2_tag_q;
`ifdef FP_TO_INT_FLAGS_EN
  logic [2:0]       s2_flags_q, s2_flags_d;
  logic [15:0]      lost;
`endif

  logic s2_ready, s1_load, s2_load;

  assign s2_ready   = !s2_v_q || out_ready_i;
  assign in_ready_o = !s1_v_q || s2_ready;
  assign s1_load    = in_valid_i && in_ready_o;
  assign s2_load    = s1_v_q && s2_ready;
  assign s1_v_d     = in_ready_o ? in_valid_i : s1_v_q;
  assign s2_v_d     = s2_ready ? s1_v_q : s2_v_q;

  fp24_classify u_classify (
    .a_i    (in_a_i),
    .sign_o (s1_sign_d),
    .cls_o  (cls_raw),
    .exp_o  (s1_e_d),
    .mant_o (s1_mant_d)
  );

  assign s1_cls_d = fp_class_e'(cls_raw);

  logic [OUT_W-1:0] mag;
  logic             sat;
  logic [3:0]       rsh;
  logic [4:0]       lsh;

  // Shift amounts are only meaningful in the exponent range that selects them.
  assign rsh = 4'(15 - s1_e_q[3:0]);
  assign lsh = 5'(s1_e_q - 9'd15);
`ifdef FP_TO_INT_FLAGS_EN
  assign lost = s1_mant_q & ~({16{1'b1}} << rsh);
`endif

  always_comb begin
    mag = '0;
    sat = 1'b0;
`ifdef FP_TO_INT_FLAGS_EN
    s2_flags_d = '0;
`endif
    unique case (s1_cls_q)
      FP_ZERO: begin
        mag = '0;
      end
      FP_NAN: begin
`ifdef FP_TO_INT_FLAGS_EN
        s2_flags_d[FLAG_INVALID] = 1'b1;
`endif
      end
      FP_INF: begin
        sat = 1'b1;
`ifdef FP_TO_INT_FLAGS_EN
        s2_flags_d[FLAG_INVALID]  = 1'b1;
        s2_flags_d[FLAG_OVERFLOW] = 1'b1;
`endif
      end
      FP_NORMAL: begin
        if (s1_e_q[8]) begin
`ifdef FP_TO_INT_FLAGS_EN
          s2_flags_d[FLAG_INEXACT] = 1'b1;
`endif
        end else if (s1_e_q < 9'd15) begin
          mag = OUT_W'(s1_mant_q >> rsh);
`ifdef FP_TO_INT_FLAGS_EN
          s2_flags_d[FLAG_INEXACT] = |lost;
`endif
        end else if (s1_e_q <= 9'(OUT_W - 2)) begin
          mag = OUT_W'(s1_mant_q) << lsh;
        end else if (s1_e_q == 9'(OUT_W - 1) && s1_sign_q && s1_mant_q[14:0] == '0) begin
          // Exactly -2^(OUT_W-1) is representable; saturation yields it without overflow.
          sat = 1'b1;
        end else begin
          sat = 1'b1;
`ifdef FP_TO_INT_FLAGS_EN
          s2_flags_d[FLAG_OVERFLOW] = 1'b1;
`endif
        end
      end
    endcase

    if (sat) begin
      s2_int_d = s1_sign_q ? INT_MIN : INT_MAX;
    end else begin
      s2_int_d = s1_sign_q ? -mag : mag;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_v_q     <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_cls_q   <= FP_ZERO;
      s1_e_q     <= '0;
      s1_mant_q  <= '0;
      s1_tag_q   <= '0;
      s2_v_q     <= 1'b0;
      s2_int_q   <= '0;
      s2_tag_q   <= '0;
`ifdef FP_TO_INT_FLAGS_EN
      s2_flags_q <= '0;
`endif
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      if (s1_load) begin
        s1_sign_q <= s1_sign_d;
        s1_cls_q  <= s1_cls_d;
        s1_e_q    <= s1_e_d;
        s1_mant_q <= s1_mant_d;
        s1_tag_q  <= in_tag_i;
      end
      if (s2_load) begin
        s2_int_q   <= s2_int_d;
        s2_tag_q   <= s1_tag_q;
`ifdef FP_TO_INT_FLAGS_EN
        s2_flags_q <= s2_flags_d;
`endif
      end
    end
  end

  assign out_valid_o = s2_v_q;
  assign out_int_o   = s2_int_q;
  assign out_tag_o   = s2_tag_q;
`ifdef FP_TO_INT_FLAGS_EN
  assign out_flags_o = s2_flags_q;
`else
  assign out_flags_o = 3'b000;
`endif

endmodule

// File: tb/tb_fp_to_int.sv
// Directed bench for fp_to_int: vector table, backpressure stall and mid-flight reset.
`timescale 1ns/1ps
module tb_fp_to_int;

  localparam int unsigned OUT_W = 32;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned NV    = 16;
`ifdef FP_TO_INT_FLAGS_EN
  localparam logic [2:0] FLAG_MASK = 3'b111;
`else
  localparam logic [2:0] FLAG_MASK = 3'b000;
`endif

  logic             clk = 1'b0;
  logic             rst_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic [23:0]      in_a_i;
  logic [TAG_W-1:0] in_tag_i, out_tag_o;
  logic [OUT_W-1:0] out_int_o;
  logic [2:0]       out_flags_o;

  always #5 clk = ~clk;

  fp_to_int #(.OUT_W(OUT_W), .TAG_W(TAG_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_a_i      (in_a_i),
    .in_tag_i    (in_tag_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_int_o   (out_int_o),
    .out_tag_o   (out_tag_o),
    .out_flags_o (out_flags_o)
  );

  typedef struct {
    logic [23:0] a;
    logic [31:0] res;
    logic [2:0]  flags;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flags;
    logic [3:0]  tag;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  exp_t expq[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   n_out  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Output monitor: in-order scoreboard, latency and stall-stability checks.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_int;
  logic [3:0]  prev_tag;
  logic [2:0]  prev_flags;

  always @(negedge clk) begin
    exp_t e;
    if (prev_stall) begin
      check("stall_hold", {out_valid_o, out_int_o, out_tag_o, out_flags_o},
                          {1'b1, prev_int, prev_tag, prev_flags});
    end
    prev_stall = out_valid_o && !out_ready_i && !rst_i;
    prev_int   = out_int_o;
    prev_tag   = out_tag_o;
    prev_flags = out_flags_o;
    if (out_valid_o && out_ready_i && !rst_i) begin
      n_out++;
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got tag %0h int %0h, required no output", out_tag_o, out_int_o);
      end else begin
        e = expq.pop_front();
        check("out_int", out_int_o, e.res);
        check("out_tag", out_tag_o, e.tag);
        check("out_flags", out_flags_o, e.flags);
        if (e.chk_lat) check("latency", 64'(cyc - e.acc_cyc), 64'd2);
      end
    end
  end

  task automatic send(input logic [23:0] a, input logic [3:0] tag,
                      input logic [31:0] res, input logic [2:0] fl, input bit lat);
    exp_t e;
    int   n;
    bit   ok;
    in_valid_i = 1'b1;
    in_a_i     = a;
    in_tag_i   = tag;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (in_ready_o) ok = 1'b1;
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready_o=0 for 50 cycles, required 1");
    end else begin
      e.res = res; e.flags = fl & FLAG_MASK; e.tag = tag; e.acc_cyc = cyc; e.chk_lat = lat;
      expq.push_back(e);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(expq.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl [NV];
    int   n0;
    tbl = '{
      '{24'h3F8000, 32'h00000001, 3'b000},  //  1.0
      '{24'hC00000, 32'hFFFFFFFE, 3'b000},  // -2.0
      '{24'h402000, 32'h00000002, 3'b001},  //  2.5
      '{24'h4F0000, 32'h7FFFFFFF, 3'b010},  //  2^31
      '{24'hCF0000, 32'h80000000, 3'b000},  // -2^31
      '{24'h3F0000, 32'h00000000, 3'b001},  //  0.5
      '{24'h7F8001, 32'h00000000, 3'b100},  //  NaN
      '{24'hFF8000, 32'h80000000, 3'b110},  // -inf
      '{24'h800000, 32'h00000000, 3'b000},  // -0
      '{24'h4EFFFF, 32'h7FFF8000, 3'b000},  //  e=30, largest in range
      '{24'hCF0001, 32'h80000000, 3'b010},  // -2^31*(1+2^-15)
      '{24'h7F8000, 32'h7FFFFFFF, 3'b110},  // +inf
      '{24'h007FFF, 32'h00000000, 3'b000},  //  denormal flushed
      '{24'h46FFFF, 32'h00007FFF, 3'b001},  //  e=14
      '{24'hBFC000, 32'hFFFFFFFF, 3'b001},  // -1.5
      '{24'h470000, 32'h00008000, 3'b000}   //  e=15
    };

    rst_i       = 1'b1;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    in_a_i      = '0;
    in_tag_i    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    check("reset_state", {out_valid_o, out_int_o, out_tag_o, out_flags_o, in_ready_o},
                         {1'b0, 32'h0, 4'h0, 3'b000, 1'b1});
    @(posedge clk);
    #1;

    // Back-to-back conversions at full throughput.
    for (int i = 0; i < int'(NV); i++) begin
      send(tbl[i].a, 4'(i), tbl[i].res, tbl[i].flags, 1'b1);
    end
    in_valid_i = 1'b0;
    drain();

    // Six operands against four stalled cycles.
    n0 = n_out;
    out_ready_i = 1'b0;
    fork
      begin
        for (int t = 0; t < 6; t++) send(tbl[t].a, 4'(t), tbl[t].res, tbl[t].flags, 1'b0);
        in_valid_i = 1'b0;
      end
    join_none
    repeat (2) @(negedge clk);
    @(negedge clk);
    check("stall_ready3", in_ready_o, 1'b0);
    check("stall_head3", {out_valid_o, out_tag_o, out_int_o}, {1'b1, 4'h0, tbl[0].res});
    @(negedge clk);
    check("stall_ready4", in_ready_o, 1'b0);
    check("stall_head4", {out_valid_o, out_tag_o, out_int_o}, {1'b1, 4'h0, tbl[0].res});
    @(posedge clk);
    #1;
    out_ready_i = 1'b1;
    wait fork;
    drain();
    check("stall_count", 64'(n_out - n0), 64'd6);

    // Reset with two entries held in the pipe.
    out_ready_i = 1'b0;
    send(tbl[1].a, 4'd9, tbl[1].res, tbl[1].flags, 1'b0);
    send(tbl[2].a, 4'd10, tbl[2].res, tbl[2].flags, 1'b0);
    in_valid_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    expq.delete();
    n0 = n_out;
    @(negedge clk);
    check("flush_state", {out_valid_o, out_int_o, out_tag_o, in_ready_o},
                         {1'b0, 32'h0, 4'h0, 1'b1});
    @(posedge clk);
    #1;
    out_ready_i = 1'b1;
    repeat (6) @(negedge clk);
    check("flush_no_emit", 64'(n_out - n0), 64'd0);
    @(posedge clk);
    #1;
    send(tbl[3].a, 4'd3, tbl[3].res, tbl[3].flags, 1'b1);
    in_valid_i = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
